// File: rtl/fir_interp2_engine.sv
// fir_interp2_engine: polyphase 2x interpolator, one coefficient MAC per cycle from a registered ROM
module fir_interp2_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  rom_addr,
   input  logic [15:0] rom_data
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
   state_t state, state_nx;
   logic [15:0] hist [32];
   logic [4:0] wptr, tap, rd_ptr;
   logic phase, acc_en;
   logic signed [15:0] hist_q;
   logic signed [31:0] prod;
   logic signed [37:0] acc, sum;
   logic signed [22:0] rnd;
   logic [15:0] sat;
   // newest sample sits just behind wptr; tap k walks k samples further back
   assign rd_ptr = wptr - 5'd1 - tap;
   // ROM and history are both one cycle late, so the product pairs the previous tap's operands
   assign prod = $signed(rom_data) * hist_q;
   assign sum = acc + (acc_en ? 38'(prod) : 38'sd0);
   assign rnd = 23'(sum >>> 15);
   assign sat = rnd > 23'sd32767 ? 16'h7fff : rnd < -23'sd32768 ? 16'h8000 : rnd[15:0];
   assign in_ready = state == IDLE;
   assign rom_addr = {phase, tap};
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next-state: 32 address cycles, one drain cycle, then hold until the output is taken
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? ISSUE : IDLE;
         ISSUE:   state_nx = (tap == 5'd31) ? DRAIN : ISSUE;
         DRAIN:   state_nx = OUT;
         OUT:     state_nx = out_ready ? (phase ? IDLE : ISSUE) : OUT;
         default: state_nx = IDLE;
      endcase
   end
   // history, tap/phase counters, accumulator and output register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) hist[i] <= '0;
         wptr      <= '0;
         tap       <= '0;
         phase     <= 1'b0;
         acc_en    <= 1'b0;
         hist_q    <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         acc_en <= state == ISSUE;
         hist_q <= $signed(hist[rd_ptr]);
         case (state)
            IDLE:
               if (in_valid) begin
                  hist[wptr] <= in_data;
                  wptr       <= wptr + 5'd1;
                  phase      <= 1'b0;
                  tap        <= '0;
                  acc        <= 38'sd16384;
               end
            ISSUE: begin
               acc <= sum;
               if (tap != 5'd31) tap <= tap + 5'd1;
            end
            DRAIN: begin
               out_data  <= sat;
               out_valid <= 1'b1;
            end
            OUT:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!phase) begin
                     phase <= 1'b1;
                     tap   <= '0;
                     acc   <= 38'sd16384;
                  end
               end
            default: ;
         endcase
      end
endmodule
